rr_step_arbiter: RTL and testbench

- Round-robin arbiter that shares one step-counting FSM datapath (x_in/y_out counter style) among N_REQ requesters.
- Grants one requester at a time and forwards that requester's step strobe onto the shared x_in line.
- Forces a one-cycle quiet gap between owners.
- Sits between the requesting control blocks and the single shared counter instance.

---
 rtl/rr_step_arbiter_if.sv | 34 +++
 rtl/rr_step_arbiter.sv | 138 +++++++++++++
 tb/tb_rr_step_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_step_arbiter_if.sv
// Requester-side bundle of the round-robin step arbiter: requests and step strobes
// flow in, and the grant, owner, hold count and forwarded step flow back out.
interface rr_step_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] step_req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  owner;
  logic             busy;
  logic             step_x;
  logic [3:0]       hold_cnt;

  modport master (
    output req,
    output step_req,
    input  gnt,
    input  owner,
    input  busy,
    input  step_x,
    input  hold_cnt
  );

  modport slave (
    input  req,
    input  step_req,
    output gnt,
    output owner,
    output busy,
    output step_x,
    output hold_cnt
  );
endinterface

// File: rtl/rr_step_arbiter.sv
// Round-robin arbiter that shares one step-counting datapath among four requesters.
// Each grant is bounded in length and is followed by a one-cycle quiet gap.
module rr_step_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst,
  rr_step_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  localparam logic [3:0]       HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [N_REQ-1:0] GNT_ONE   = N_REQ'(1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic [3:0]       hold_q, hold_d;

  logic             win_found;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  scan_idx;
  logic             release_now;

  // Scan from ptr upward, wrapping, and keep the first requester found.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = ptr_q + ID_W'(k);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign release_now = !bus.req[owner_q] || (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE, RELEASE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        hold_d = '0;
        if (win_found) begin
          state_d = GRANT;
          owner_d = win_idx;
          gnt_d   = GNT_ONE << win_idx;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      // Requests from other requesters never pre-empt the current owner.
      GRANT: begin
        if (release_now) begin
          state_d = RELEASE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          hold_d  = '0;
          ptr_d   = owner_q + ID_W'(1);
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  // The step strobe is gated only by registered state, so it cannot glitch on arbitration.
  assign bus.gnt      = gnt_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;
  assign bus.hold_cnt = hold_q;
  assign bus.step_x   = (state_q == GRANT) & bus.step_req[owner_q];

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt_q));

  a_busy_match: assert property (@(posedge clk) disable iff (rst)
    busy_q == (|gnt_q));

  a_step_busy: assert property (@(posedge clk) disable iff (rst)
    bus.step_x |-> busy_q);

  a_hold_bound: assert property (@(posedge clk) disable iff (rst)
    hold_q <= HOLD_LAST);

  a_single_gap: assert property (@(posedge clk) disable iff (rst)
    (state_q == RELEASE) |=> (state_q != RELEASE));

  a_owner_stable: assert property (@(posedge clk) disable iff (rst)
    (state_q == GRANT && state_d == GRANT) |=> (owner_q == $past(owner_q)));

endmodule

// File: tb/tb_rr_step_arbiter.sv
// Randomized self-checking bench for rr_step_arbiter against a cycle-level
// reference model built from the round-robin grant rules.
module tb_rr_step_arbiter;
  localparam int N_REQ    = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_step_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus();

  rr_step_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who holds the counter, for how long, and where the search starts.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_held;

  function automatic int pick(int base, logic [N_REQ-1:0] r);
    for (int k = 0; k < N_REQ; k++)
      if (r[(base + k) % N_REQ]) return (base + k) % N_REQ;
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] exp_gnt();
    logic [N_REQ-1:0] g;
    g = '0;
    if (m_busy) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic exp_step();
    return m_busy && bus.step_req[m_owner];
  endfunction

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0;
    end else if (m_busy) begin
      if (!bus.req[m_owner] || m_held == MAX_HOLD - 1) begin
        m_busy = 0;
        m_held = 0;
        m_ptr  = (m_owner + 1) % N_REQ;
      end else begin
        m_held++;
      end
    end else if (bus.req != '0) begin
      m_owner = pick(m_ptr, bus.req);
      m_busy  = 1;
      m_held  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.step_req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'($urandom);
    bus.step_req = 4'($urandom);
    repeat (2) tick();
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_gnt: got %b want 0000", bus.gnt); end
    vectors++; if (bus.owner !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_owner: got %0d want 0", bus.owner); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.hold_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_hold: got %0d want 0", bus.hold_cnt); end
    vectors++; if (bus.step_x !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_step_x: got %b want 0", bus.step_x); end
    rst = 1'b0;
    bus.req = '0;
    bus.step_req = '0;
  endtask

  task automatic test_single_request();
    bus.req = '0;
    tick();
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("[TB] FAIL single_idle: got %b want 0000", bus.gnt); end
    bus.req = 4'b0100;
    tick();
    vectors++; if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2 || bus.busy !== 1'b1)
      begin miscompares++; $display("[TB] FAIL single_grant: got gnt=%b owner=%0d busy=%b want 0100/2/1", bus.gnt, bus.owner, bus.busy); end
    repeat (2) tick();
    vectors++; if (bus.hold_cnt !== 4'd2) begin miscompares++; $display("[TB] FAIL single_hold: got %0d want 2", bus.hold_cnt); end
    bus.req = '0;
    tick();
    vectors++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd2)
      begin miscompares++; $display("[TB] FAIL single_release: got gnt=%b busy=%b owner=%0d want 0000/0/2", bus.gnt, bus.busy, bus.owner); end
    tick();
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("[TB] FAIL single_idle_after: got %b want 0000", bus.gnt); end
    bus.req = 4'b1001;
    tick();
    vectors++; if (bus.owner !== 2'd3 || bus.gnt !== 4'b1000)
      begin miscompares++; $display("[TB] FAIL single_ptr3: got owner=%0d gnt=%b want 3/1000", bus.owner, bus.gnt); end
    bus.req = '0;
    repeat (2) tick();
  endtask

  task automatic test_all_requests();
    int owners[$];
    int lens[$];
    int gaps[$];
    int run;
    int gap;
    logic [N_REQ-1:0] prev;
    int want_owner;
    do_reset();
    bus.req = 4'b1111;
    prev = '0; run = 0; gap = 0;
    for (int c = 0; c < 5 * (MAX_HOLD + 1); c++) begin
      tick();
      vectors++; if (bus.gnt !== exp_gnt() || bus.hold_cnt !== 4'(m_held))
        begin miscompares++; $display("[TB] FAIL all_req_cycle%0d: got gnt=%b hold=%0d want %b/%0d", c, bus.gnt, bus.hold_cnt, exp_gnt(), m_held); end
      if (bus.gnt != '0) begin
        if (prev == '0) begin
          owners.push_back(int'(bus.owner));
          if (owners.size() > 1) gaps.push_back(gap);
          run = 0;
        end
        run++;
      end else begin
        if (prev != '0) begin lens.push_back(run); gap = 0; end
        gap++;
      end
      prev = bus.gnt;
    end
    vectors++; if (owners.size() != 5 || lens.size() != 5 || gaps.size() != 4)
      begin miscompares++; $display("[TB] FAIL all_req_counts: got grants=%0d lens=%0d gaps=%0d want 5/5/4", owners.size(), lens.size(), gaps.size()); end
    for (int i = 0; i < owners.size(); i++) begin
      want_owner = i % N_REQ;
      vectors++; if (owners[i] != want_owner) begin miscompares++; $display("[TB] FAIL all_req_owner%0d: got %0d want %0d", i, owners[i], want_owner); end
    end
    foreach (lens[i]) begin
      vectors++; if (lens[i] != MAX_HOLD) begin miscompares++; $display("[TB] FAIL all_req_len%0d: got %0d want %0d", i, lens[i], MAX_HOLD); end
    end
    foreach (gaps[i]) begin
      vectors++; if (gaps[i] != 1) begin miscompares++; $display("[TB] FAIL all_req_gap%0d: got %0d want 1", i, gaps[i]); end
    end
  endtask

  task automatic test_step_forwarding();
    int dut_pulses;
    int exp_pulses;
    do_reset();
    dut_pulses = 0; exp_pulses = 0;
    for (int c = 0; c < 30; c++) begin
      bus.req = (c < 12) ? 4'b0010 : 4'b0000;
      bus.step_req = (c % 2 == 0) ? 4'b1111 : (4'($urandom) & 4'b1101);
      #1;
      vectors++; if (bus.step_x !== exp_step())
        begin miscompares++; $display("[TB] FAIL step_x_cycle%0d: got %b want %b (step_req=%b)", c, bus.step_x, exp_step(), bus.step_req); end
      dut_pulses += int'(bus.step_x);
      exp_pulses += int'(exp_step());
      tick();
      vectors++; if (bus.gnt !== exp_gnt()) begin miscompares++; $display("[TB] FAIL step_gnt_cycle%0d: got %b want %b", c, bus.gnt, exp_gnt()); end
    end
    vectors++; if (dut_pulses != exp_pulses || exp_pulses == 0)
      begin miscompares++; $display("[TB] FAIL step_pulse_count: got %0d want %0d", dut_pulses, exp_pulses); end
    bus.step_req = '0;
  endtask

  task automatic test_self_regrant();
    logic [N_REQ-1:0] want;
    do_reset();
    bus.req = 4'b1000;
    for (int c = 0; c < 2 * (MAX_HOLD + 1) + 3; c++) begin
      tick();
      want = (c % (MAX_HOLD + 1) < MAX_HOLD) ? 4'b1000 : 4'b0000;
      vectors++; if (bus.gnt !== want || bus.owner !== 2'd3)
        begin miscompares++; $display("[TB] FAIL regrant_cycle%0d: got gnt=%b owner=%0d want %b/3", c, bus.gnt, bus.owner, want); end
    end
    bus.req = '0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_grant();
    bit found;
    do_reset();
    bus.req = 4'b0100;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (bus.hold_cnt == 4'd4 && bus.owner == 2'd2) found = 1;
    end
    vectors++; if (!found) begin miscompares++; $display("[TB] FAIL midreset_wait: got no hold_cnt=4 want hold_cnt=4 within 20 cycles"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (bus.gnt !== 4'b0000 || bus.owner !== 2'd0 || bus.hold_cnt !== 4'd0 || bus.busy !== 1'b0)
      begin miscompares++; $display("[TB] FAIL midreset_state: got gnt=%b owner=%0d hold=%0d busy=%b want 0000/0/0/0", bus.gnt, bus.owner, bus.hold_cnt, bus.busy); end
    bus.req = 4'b1111;
    tick();
    vectors++; if (bus.owner !== 2'd0 || bus.gnt !== 4'b0001)
      begin miscompares++; $display("[TB] FAIL midreset_ptr0: got owner=%0d gnt=%b want 0/0001", bus.owner, bus.gnt); end
    bus.req = '0;
    repeat (2) tick();
  endtask

  task automatic test_drop_at_limit();
    bit found;
    do_reset();
    bus.req = 4'b0001;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (bus.hold_cnt == 4'(MAX_HOLD - 1)) found = 1;
    end
    vectors++; if (!found) begin miscompares++; $display("[TB] FAIL drop_wait: got no hold limit want hold_cnt=%0d within 20 cycles", MAX_HOLD - 1); end
    bus.req = 4'b0010;
    tick();
    vectors++; if (bus.gnt !== 4'b0000 || bus.owner !== 2'd0)
      begin miscompares++; $display("[TB] FAIL drop_release: got gnt=%b owner=%0d want 0000/0", bus.gnt, bus.owner); end
    bus.req = 4'b0011;
    tick();
    vectors++; if (bus.owner !== 2'd1 || bus.gnt !== 4'b0010)
      begin miscompares++; $display("[TB] FAIL drop_next_owner: got owner=%0d gnt=%b want 1/0010", bus.owner, bus.gnt); end
    bus.req = '0;
    repeat (2) tick();
  endtask

  task automatic test_random_soak();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(5) == 0) bus.req = 4'($urandom);
      bus.step_req = 4'($urandom);
      rst = ($urandom_range(59) == 0);
      #1;
      vectors++; if (bus.step_x !== exp_step())
        begin miscompares++; $display("[TB] FAIL soak_step_x%0d: got %b want %b", c, bus.step_x, exp_step()); end
      tick();
      vectors++; if (bus.gnt !== exp_gnt() || bus.busy !== m_busy || bus.owner !== ID_W'(m_owner) || bus.hold_cnt !== 4'(m_held))
        begin miscompares++; $display("[TB] FAIL soak_cycle%0d: got gnt=%b busy=%b owner=%0d hold=%0d want %b/%b/%0d/%0d",
          c, bus.gnt, bus.busy, bus.owner, bus.hold_cnt, exp_gnt(), m_busy, m_owner, m_held); end
    end
    rst = 1'b0;
    bus.req = '0;
    bus.step_req = '0;
  endtask

  initial begin
    bus.req = '0;
    bus.step_req = '0;
    test_reset();
    test_single_request();
    test_all_requests();
    test_step_forwarding();
    test_self_regrant();
    test_reset_mid_grant();
    test_drop_at_limit();
    test_random_soak();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
